// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the single-issue MIPS subset core (R-type, addi, slti, beq).
// Sequences fetch/decode/execute/write-back, traps on illegal opcodes and fetch timeouts.
module multicycle_ctrl #(
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             halt_i,
  input  logic [5:0]       instr_op_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             reg_write_o,
  output logic [2:0]       alu_op_o,
  output logic             alu_src_o,
  output logic             reg_dst_o,
  output logic             branch_o,
  output logic             busy_o,
  output logic [1:0]       fault_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned TW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'b00,
    F_ILLEGAL = 2'b01,
    F_TIMEOUT = 2'b10
  } fault_t;

  state_t           state_q, state_d;
  fault_t           fault_q, fault_d;
  logic [5:0]       op_q;
  logic [TW-1:0]    to_cnt_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // Next-state, handshake and write strobes.
  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    retire      = 1'b0;
    imem_req_o  = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    reg_write_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!halt_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        ir_write_o = imem_ack_i;
        // An ack on the threshold cycle still wins over the timeout.
        if (imem_ack_i) begin
          state_d = S_DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_TRAP;
          fault_d = F_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ: state_d = S_EXEC;
          default: begin
            state_d = S_TRAP;
            fault_d = F_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        if (op_q == OP_BEQ) begin
          pc_write_o = 1'b1;
          retire     = 1'b1;
          state_d    = halt_i ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write_o = 1'b1;
        pc_write_o  = 1'b1;
        retire      = 1'b1;
        state_d     = halt_i ? S_IDLE : S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath controls decoded from the latched opcode, live only in EXEC and WB.
  always_comb begin
    alu_op_o  = '0;
    alu_src_o = 1'b0;
    reg_dst_o = 1'b0;
    branch_o  = 1'b0;
    if (state_q == S_EXEC || state_q == S_WB) begin
      case (op_q)
        OP_RTYPE: begin
          alu_op_o  = 3'b100;
          reg_dst_o = 1'b1;
        end
        OP_ADDI: begin
          alu_op_o  = 3'b000;
          alu_src_o = 1'b1;
        end
        OP_SLTI: begin
          alu_op_o  = 3'b010;
          alu_src_o = 1'b1;
        end
        OP_BEQ: begin
          alu_op_o = 3'b001;
          branch_o = 1'b1;
        end
        default: begin
          alu_op_o = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      fault_q   <= F_NONE;
      op_q      <= '0;
      to_cnt_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (state_q == S_DECODE) op_q <= instr_op_i;
      // Counter runs only while in FETCH, so it is zero on every entry.
      to_cnt_q <= (state_q == S_FETCH) ? to_cnt_q + TW'(1) : '0;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign busy_o    = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign fault_o   = fault_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each task runs a table of per-cycle stimulus
// and hand-computed output vectors, comparing inline.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [5:0]  instr_op;
  logic        imem_ack;
  logic        imem_req, ir_write, pc_write, reg_write;
  logic [2:0]  alu_op;
  logic        alu_src, reg_dst, branch, busy;
  logic [1:0]  fault;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;

  // {req, ir_w, pc_w, reg_w, alu_op, alu_src, reg_dst, branch, busy, fault}
  localparam logic [13:0] V_IDLE    = '0;
  localparam logic [13:0] V_FACK    = {1'b1,1'b1,1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_FWAIT   = {1'b1,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_DEC     = {1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_EX_R    = {1'b0,1'b0,1'b0,1'b0,3'b100,1'b0,1'b1,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_WB_R    = {1'b0,1'b0,1'b1,1'b1,3'b100,1'b0,1'b1,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_EX_ADDI = {1'b0,1'b0,1'b0,1'b0,3'b000,1'b1,1'b0,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_WB_ADDI = {1'b0,1'b0,1'b1,1'b1,3'b000,1'b1,1'b0,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_EX_SLTI = {1'b0,1'b0,1'b0,1'b0,3'b010,1'b1,1'b0,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_WB_SLTI = {1'b0,1'b0,1'b1,1'b1,3'b010,1'b1,1'b0,1'b0,1'b1,2'b00};
  localparam logic [13:0] V_EX_BEQ  = {1'b0,1'b0,1'b1,1'b0,3'b001,1'b0,1'b0,1'b1,1'b1,2'b00};
  localparam logic [13:0] V_TRAP_TO = {1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,1'b0,2'b10};
  localparam logic [13:0] V_TRAP_IL = {1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,1'b0,2'b01};

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic        ack;
    logic        halt;
    logic [13:0] vec;
    logic [15:0] ret;
  } step_t;

  multicycle_ctrl #(
    .FETCH_TIMEOUT(16),
    .CNT_W        (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .halt_i     (halt),
    .instr_op_i (instr_op),
    .imem_ack_i (imem_ack),
    .imem_req_o (imem_req),
    .ir_write_o (ir_write),
    .pc_write_o (pc_write),
    .reg_write_o(reg_write),
    .alu_op_o   (alu_op),
    .alu_src_o  (alu_src),
    .reg_dst_o  (reg_dst),
    .branch_o   (branch),
    .busy_o     (busy),
    .fault_o    (fault),
    .retired_o  (retired)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic r, input logic [5:0] op, input logic a,
                               input logic h, input logic [13:0] v, input logic [15:0] rt);
    step_t s;
    s.rst = r; s.op = op; s.ack = a; s.halt = h; s.vec = v; s.ret = rt;
    return s;
  endfunction

  // Drive one cycle's inputs, sample outputs mid-cycle, then advance past the edge.
  task automatic cyc(input logic r, input logic [5:0] op, input logic a, input logic h,
                     output logic [13:0] o, output logic [15:0] rt);
    rst = r; instr_op = op; imem_ack = a; halt = h;
    #1;
    o  = {imem_req, ir_write, pc_write, reg_write, alu_op, alu_src, reg_dst, branch, busy, fault};
    rt = retired;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic [13:0] o;
    logic [15:0] rt;
    cyc(1'b1, OP_R, 1'b0, 1'b1, o, rt);
  endtask

  task automatic test_reset();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    cyc(1'b1, OP_R, 1'b1, 1'b0, o, rt);
    q.push_back(mk(1'b1, OP_R, 1'b1, 1'b0, V_IDLE, 16'd0));
    q.push_back(mk(1'b1, OP_R, 1'b1, 1'b0, V_IDLE, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_IDLE, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_IDLE, 16'd0));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL reset step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  task automatic test_rtype();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    do_reset();
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_IDLE, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_DEC,  16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_EX_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_WB_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd1));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL rtype step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  task automatic test_sequence();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    do_reset();
    q.push_back(mk(1'b0, OP_ADDI, 1'b1, 1'b0, V_IDLE,    16'd0));
    q.push_back(mk(1'b0, OP_ADDI, 1'b1, 1'b0, V_FACK,    16'd0));
    q.push_back(mk(1'b0, OP_ADDI, 1'b1, 1'b0, V_DEC,     16'd0));
    q.push_back(mk(1'b0, OP_ADDI, 1'b1, 1'b0, V_EX_ADDI, 16'd0));
    q.push_back(mk(1'b0, OP_ADDI, 1'b1, 1'b0, V_WB_ADDI, 16'd0));
    q.push_back(mk(1'b0, OP_SLTI, 1'b1, 1'b0, V_FACK,    16'd1));
    q.push_back(mk(1'b0, OP_SLTI, 1'b1, 1'b0, V_DEC,     16'd1));
    q.push_back(mk(1'b0, OP_SLTI, 1'b1, 1'b0, V_EX_SLTI, 16'd1));
    q.push_back(mk(1'b0, OP_SLTI, 1'b1, 1'b0, V_WB_SLTI, 16'd1));
    q.push_back(mk(1'b0, OP_BEQ,  1'b1, 1'b0, V_FACK,    16'd2));
    q.push_back(mk(1'b0, OP_BEQ,  1'b1, 1'b0, V_DEC,     16'd2));
    q.push_back(mk(1'b0, OP_BEQ,  1'b1, 1'b0, V_EX_BEQ,  16'd2));
    q.push_back(mk(1'b0, OP_R,    1'b1, 1'b0, V_FACK,    16'd3));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL sequence step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  task automatic test_ack_delay();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    do_reset();
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_IDLE, 16'd0));
    for (int k = 0; k < 5; k++) q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_FWAIT, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_DEC,  16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_EX_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_WB_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd1));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL ack_delay step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  task automatic test_timeout();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    do_reset();
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_IDLE, 16'd0));
    for (int k = 0; k < 16; k++) q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_FWAIT, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_TRAP_TO, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_TRAP_TO, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_TRAP_TO, 16'd0));
    q.push_back(mk(1'b1, OP_R, 1'b1, 1'b1, V_TRAP_TO, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_IDLE,    16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_IDLE,    16'd0));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL timeout step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  task automatic test_ack_threshold();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    do_reset();
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_IDLE, 16'd0));
    for (int k = 0; k < 15; k++) q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_FWAIT, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_DEC,  16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_EX_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b0, 1'b0, V_WB_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd1));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL ack_threshold step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  task automatic test_illegal();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    do_reset();
    q.push_back(mk(1'b0, OP_R,  1'b1, 1'b0, V_IDLE,    16'd0));
    q.push_back(mk(1'b0, OP_R,  1'b1, 1'b0, V_FACK,    16'd0));
    q.push_back(mk(1'b0, OP_R,  1'b1, 1'b0, V_DEC,     16'd0));
    q.push_back(mk(1'b0, OP_R,  1'b1, 1'b0, V_EX_R,    16'd0));
    q.push_back(mk(1'b0, OP_R,  1'b1, 1'b0, V_WB_R,    16'd0));
    q.push_back(mk(1'b0, OP_LW, 1'b1, 1'b0, V_FACK,    16'd1));
    q.push_back(mk(1'b0, OP_LW, 1'b1, 1'b0, V_DEC,     16'd1));
    q.push_back(mk(1'b0, OP_R,  1'b1, 1'b0, V_TRAP_IL, 16'd1));
    q.push_back(mk(1'b0, OP_R,  1'b1, 1'b1, V_TRAP_IL, 16'd1));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL illegal step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  task automatic test_halt();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    do_reset();
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_IDLE, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_DEC,  16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_EX_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_WB_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_IDLE, 16'd1));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_IDLE, 16'd1));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd1));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL halt step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  task automatic test_reset_mid_wb();
    step_t q[$];
    logic [13:0] o;
    logic [15:0] rt;
    do_reset();
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_IDLE, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_DEC,  16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_EX_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_WB_R, 16'd0));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_FACK, 16'd1));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_DEC,  16'd1));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b0, V_EX_R, 16'd1));
    q.push_back(mk(1'b1, OP_R, 1'b1, 1'b0, V_WB_R, 16'd1));
    q.push_back(mk(1'b0, OP_R, 1'b1, 1'b1, V_IDLE, 16'd0));
    foreach (q[i]) begin
      cyc(q[i].rst, q[i].op, q[i].ack, q[i].halt, o, rt);
      checks++;
      if ({o, rt} !== {q[i].vec, q[i].ret}) begin
        errors++;
        $display("FAIL reset_mid_wb step %0d: got vec=%b ret=%0d, expected vec=%b ret=%0d", i, o, rt, q[i].vec, q[i].ret);
      end
    end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b1; instr_op = '0; imem_ack = 1'b0;
    test_reset();
    test_rtype();
    test_sequence();
    test_ack_delay();
    test_timeout();
    test_ack_threshold();
    test_illegal();
    test_halt();
    test_reset_mid_wb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
